// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type and default parameters for the APB memory slave
// Exports apb_st_e and the DEF_* defaults used by apb_slave_mem and apb_mem_array.
package apb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} apb_st_e;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_RO_WORDS = 1;
  localparam int DEF_MAX_WAIT = 7;
  localparam logic [31:0] DEF_RO_VALUE = 32'hA9B0_0001;
endpackage

// File: rtl/apb_mem_array.sv
// apb_mem_array: DEPTH x DATA_WIDTH flop array with byte-lane writes, async clear
// Ports: pclk/preset clock and async active-high reset; we/widx/wdata/wstrb write port;
//        ridx/rdata combinational read port.
module apb_mem_array
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    we,
  input  logic [IW-1:0]           widx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [IW-1:0]           ridx,
  output logic [DATA_WIDTH-1:0]   rdata
);
  localparam int NB = DATA_WIDTH / 8;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge pclk or posedge preset)
    if (preset)
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we)
      for (int i = 0; i < NB; i++)
        if (wstrb[i]) mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
  assign rdata = mem[ridx];
endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB4 completer with wait states, read-only region, errors and error counter
// Ports: pclk/preset clock and async active-high reset; psel/penable/pwrite/paddr/pwdata/pstrb
//        APB request; wait_cfg wait states sampled at setup; pready/prdata/pslverr registered
//        response; err_count saturating errored-transfer count.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int          ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int          DEPTH = DEF_DEPTH,
  parameter int          RO_WORDS = DEF_RO_WORDS,
  parameter logic [31:0] RO_VALUE = DEF_RO_VALUE,
  parameter int          MAX_WAIT = DEF_MAX_WAIT,
  parameter int          WW = $clog2(MAX_WAIT + 1)
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [WW-1:0]           wait_cfg,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr,
  output logic [7:0]              err_count
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(NB - 1);
  localparam logic [DATA_WIDTH-1:0] RO_DATA = DATA_WIDTH'(RO_VALUE);
  apb_st_e st;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         strb_q;
  logic [WW-1:0]         cnt;
  logic [WW-1:0]         wait_c;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic                  a_write;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [NB-1:0]         a_strb;
  logic [ADDR_WIDTH-1:0] word;
  logic                  setup;
  logic                  fire;
  logic                  ro;
  logic                  err;
  logic                  we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] rd_val;
  // A zero-wait transfer completes on its setup edge, so decode must see the live bus
  // there; every later completion uses the request latched at setup.
  always_comb begin
    wait_c = (32'(wait_cfg) > 32'(MAX_WAIT)) ? WW'(MAX_WAIT) : wait_cfg;
    a_addr = (st == ACCESS) ? addr_q : paddr;
    a_write = (st == ACCESS) ? write_q : pwrite;
    a_wdata = (st == ACCESS) ? wdata_q : pwdata;
    a_strb = (st == ACCESS) ? strb_q : pstrb;
    word = a_addr >> LSB;
    setup = (st != ACCESS) && psel && !penable;
    fire = setup ? (wait_c == '0) : (st == ACCESS && psel && penable && cnt == WW'(1));
    ro = 32'(word) < 32'(RO_WORDS);
    err = |(a_addr & LOW_MASK) || 32'(word) >= 32'(DEPTH) || (a_write && ro);
    we = fire && a_write && !err;
    rd_val = ro ? RO_DATA : mem_rdata;
  end
  apb_mem_array #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .IW(IW)) u_mem (
    .pclk  (pclk),
    .preset(preset),
    .we    (we),
    .widx  (IW'(word)),
    .wdata (a_wdata),
    .wstrb (a_strb),
    .ridx  (IW'(word)),
    .rdata (mem_rdata)
  );
  // The counter holds the number of penable edges still needed; reaching 1 means the
  // current edge is the last one, so pready is registered and the write commits now.
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      st <= IDLE;
      addr_q <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q <= '0;
      cnt <= '0;
      pready <= 1'b0;
      prdata <= '0;
      pslverr <= 1'b0;
      err_count <= '0;
    end else begin
      pready <= fire;
      pslverr <= fire && err;
      prdata <= (fire && !a_write && !err) ? rd_val : '0;
      if (fire && err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      st <= fire ? DONE : setup ? ACCESS : (st == ACCESS && psel) ? ACCESS : IDLE;
      if (setup) begin
        addr_q <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
        strb_q <= pstrb;
        cnt <= wait_c;
      end else if (st == ACCESS && psel && penable) cnt <= cnt - WW'(1);
    end
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed self-checking bench for apb_slave_mem
module tb_apb_slave_mem;
  logic        pclk;
  logic        preset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [8:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  wait_cfg;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [7:0]  err_count;
  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic        er;
  int          cyc;

  apb_slave_mem #(.ADDR_WIDTH(9)) dut (
    .pclk     (pclk),
    .preset   (preset),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pstrb    (pstrb),
    .wait_cfg (wait_cfg),
    .pready   (pready),
    .prdata   (prdata),
    .pslverr  (pslverr),
    .err_count(err_count)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transfer; returns read data, error flag and access cycles until pready.
  task automatic xfer(input logic wr, input logic [8:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] w,
                      output logic [31:0] rdo, output logic ero, output int cy);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; wait_cfg = w;
    @(posedge pclk); #1 penable = 1'b1;
    cy = 0; rdo = 'x; ero = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      cy++;
      if (pready) begin
        rdo = prdata;
        ero = pslverr;
        break;
      end
      @(posedge pclk); #1;
    end
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; wait_cfg = '0;
    #2 preset = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    preset = 1'b0;
    @(posedge pclk); #1;

    xfer(1'b1, 9'h008, 32'hDEADBEEF, 4'hF, 3'd0, rd, er, cyc);
    chk("wr0_err", 32'(er), 32'd0);
    chk("wr0_cycles", 32'(cyc), 32'd1);
    xfer(1'b0, 9'h008, 32'h0, 4'h0, 3'd0, rd, er, cyc);
    chk("rd0_data", rd, 32'hDEADBEEF);
    chk("rd0_err", 32'(er), 32'd0);
    chk("rd0_cycles", 32'(cyc), 32'd1);
    @(negedge pclk);
    chk("hold_pready", 32'(pready), 32'd0);
    chk("hold_prdata", prdata, 32'd0);

    xfer(1'b1, 9'h008, 32'h11223344, 4'b0101, 3'd0, rd, er, cyc);
    xfer(1'b0, 9'h008, 32'h0, 4'hF, 3'd0, rd, er, cyc);
    chk("lane_data", rd, 32'hDE22BE44);

    xfer(1'b1, 9'h00C, 32'hCAFEF00D, 4'h0, 3'd0, rd, er, cyc);
    chk("strb0_err", 32'(er), 32'd0);
    xfer(1'b0, 9'h00C, 32'h0, 4'h0, 3'd0, rd, er, cyc);
    chk("strb0_data", rd, 32'd0);

    xfer(1'b0, 9'h004, 32'h0, 4'h0, 3'd3, rd, er, cyc);
    chk("wait3_cycles", 32'(cyc), 32'd4);
    chk("wait3_data", rd, 32'd0);
    chk("wait3_err", 32'(er), 32'd0);

    xfer(1'b0, 9'h000, 32'h0, 4'h0, 3'd0, rd, er, cyc);
    chk("ro_read", rd, 32'hA9B00001);

    xfer(1'b1, 9'h000, 32'h12345678, 4'hF, 3'd0, rd, er, cyc);
    chk("err_ro_wr", 32'(er), 32'd1);
    xfer(1'b0, 9'h100, 32'h0, 4'h0, 3'd0, rd, er, cyc);
    chk("err_oob", 32'(er), 32'd1);
    chk("err_oob_data", rd, 32'd0);
    xfer(1'b0, 9'h006, 32'h0, 4'h0, 3'd0, rd, er, cyc);
    chk("err_unal", 32'(er), 32'd1);
    @(negedge pclk);
    chk("err_count3", 32'(err_count), 32'd3);
    xfer(1'b1, 9'h00A, 32'hFFFFFFFF, 4'hF, 3'd0, rd, er, cyc);
    chk("err_unal_wr", 32'(er), 32'd1);
    xfer(1'b0, 9'h008, 32'h0, 4'h0, 3'd0, rd, er, cyc);
    chk("err_mem_kept", rd, 32'hDE22BE44);
    xfer(1'b0, 9'h000, 32'h0, 4'h0, 3'd0, rd, er, cyc);
    chk("err_ro_kept", rd, 32'hA9B00001);

    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h010; pwdata = 32'h55AA55AA;
    pstrb = 4'hF; wait_cfg = 3'd3;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk);
    chk("abort_c1", 32'(pready), 32'd0);
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("abort_nordy", 32'(pready), 32'd0);
    end
    @(posedge pclk); #1;
    xfer(1'b0, 9'h010, 32'h0, 4'h0, 3'd0, rd, er, cyc);
    chk("abort_word", rd, 32'd0);

    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h014; pwdata = 32'h77777777;
    pstrb = 4'hF; wait_cfg = 3'd2;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk);
    preset = 1'b1;
    #1;
    chk("arst_errcnt", 32'(err_count), 32'd0);
    chk("arst_pready", 32'(pready), 32'd0);
    chk("arst_prdata", prdata, 32'd0);
    psel = 1'b0; penable = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk) preset = 1'b0;
    @(posedge pclk); #1;
    xfer(1'b0, 9'h014, 32'h0, 4'h0, 3'd0, rd, er, cyc);
    chk("arst_nowrite", rd, 32'd0);
    xfer(1'b0, 9'h008, 32'h0, 4'h0, 3'd0, rd, er, cyc);
    chk("arst_memclr", rd, 32'd0);

    for (int i = 0; i < 254; i++) xfer(1'b0, 9'h006, 32'h0, 4'h0, 3'd0, rd, er, cyc);
    @(negedge pclk);
    chk("sat_254", 32'(err_count), 32'd254);
    for (int i = 0; i < 46; i++) xfer(1'b0, 9'h006, 32'h0, 4'h0, 3'd0, rd, er, cyc);
    @(negedge pclk);
    chk("sat_300", 32'(err_count), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
